// File: rtl/mips_isa_pkg.sv
// MIPS opcode constants, request class encodings and loader FSM states
// shared by the instruction encoder and its loader.
package mips_isa_pkg;

  localparam logic [2:0] CLS_R      = 3'd0;
  localparam logic [2:0] CLS_IMM    = 3'd1;
  localparam logic [2:0] CLS_LOAD   = 3'd2;
  localparam logic [2:0] CLS_STORE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;
  localparam logic [2:0] CLS_JUMP   = 3'd5;

  localparam logic [5:0] OP_R         = 6'b000000;
  localparam logic [2:0] OP_IMM_PFX   = 3'b001;
  localparam logic [3:0] OP_LOAD_PFX  = 4'b1000;
  localparam logic [3:0] OP_STORE_PFX = 4'b1010;
  localparam logic [5:0] OP_BEQ       = 6'b000100;
  localparam logic [5:0] OP_BNE       = 6'b000101;
  localparam logic [5:0] OP_J         = 6'b000010;
  localparam logic [5:0] OP_JAL       = 6'b000011;

  localparam logic [2:0] LUI_LOW = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } ldr_state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: decoded instruction fields to a 32-bit MIPS word,
// flagging request classes that have no encoding.
module instr_pack
  import mips_isa_pkg::*;
(
  input  logic [2:0]  req_class,
  input  logic [5:0]  req_func,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_shamt,
  input  logic [15:0] req_imm,
  input  logic [25:0] req_target,
  output logic [31:0] word,
  output logic        illegal
);

  logic [4:0] imm_rs;

  // LUI has no source register; the field must encode as zero.
  assign imm_rs = (req_func[2:0] == LUI_LOW) ? 5'd0 : req_rs;

  always_comb begin
    word    = 32'd0;
    illegal = 1'b0;
    case (req_class)
      CLS_R:      word = {OP_R, req_rs, req_rt, req_rd, req_shamt, req_func};
      CLS_IMM:    word = {OP_IMM_PFX, req_func[2:0], imm_rs, req_rt, req_imm};
      CLS_LOAD:   word = {OP_LOAD_PFX, req_func[1:0], req_rs, req_rt, req_imm};
      CLS_STORE:  word = {OP_STORE_PFX, req_func[1:0], req_rs, req_rt, req_imm};
      CLS_BRANCH: word = {(req_func[0] ? OP_BNE : OP_BEQ), req_rs, req_rt, req_imm};
      CLS_JUMP:   word = {(req_func[0] ? OP_JAL : OP_J), req_target};
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Session-based loader: accepts decoded instruction requests, encodes them
// and writes them to consecutive instruction-memory addresses from a base.
module instr_encode_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_class,
  input  logic [5:0]        req_func,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_illegal,
  output logic              full
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

  ldr_state_t        state_reg;
  logic              req_ready_reg;
  logic              imem_we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       word_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [ADDR_W:0]   word_count_reg;
  logic              err_illegal_reg;
  logic              full_reg;
  logic              pend_finish_reg;

  logic [31:0]       packed_word;
  logic              packed_illegal;
  logic [ADDR_W:0]   count_next;

  instr_pack u_pack (
    .req_class  (req_class),
    .req_func   (req_func),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_rd     (req_rd),
    .req_shamt  (req_shamt),
    .req_imm    (req_imm),
    .req_target (req_target),
    .word       (packed_word),
    .illegal    (packed_illegal)
  );

  assign count_next = word_count_reg + (ADDR_W+1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      req_ready_reg   <= 1'b0;
      imem_we_reg     <= 1'b0;
      addr_reg        <= '0;
      word_reg        <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      word_count_reg  <= '0;
      err_illegal_reg <= 1'b0;
      full_reg        <= 1'b0;
      pend_finish_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            addr_reg        <= base_addr;
            word_count_reg  <= '0;
            err_illegal_reg <= 1'b0;
            full_reg        <= 1'b0;
            pend_finish_reg <= 1'b0;
            req_ready_reg   <= 1'b1;
            busy_reg        <= 1'b1;
            state_reg       <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (req_valid && !packed_illegal) begin
            word_reg        <= packed_word;
            imem_we_reg     <= 1'b1;
            req_ready_reg   <= 1'b0;
            pend_finish_reg <= finish;
            state_reg       <= ST_WRITE;
          end else begin
            // An illegal request is consumed silently apart from the sticky flag.
            if (req_valid) begin
              err_illegal_reg <= 1'b1;
            end
            if (finish) begin
              req_ready_reg <= 1'b0;
              done_reg      <= 1'b1;
              state_reg     <= ST_DONE;
            end
          end
        end
        ST_WRITE: begin
          if (imem_ready) begin
            imem_we_reg    <= 1'b0;
            addr_reg       <= addr_reg + 1'b1;
            word_count_reg <= count_next;
            if (count_next == MAX_CNT) begin
              full_reg  <= 1'b1;
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else if (pend_finish_reg || finish) begin
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              req_ready_reg <= 1'b1;
              state_reg     <= ST_ACCEPT;
            end
          end else if (finish) begin
            pend_finish_reg <= 1'b1;
          end
        end
        default: begin
          done_reg        <= 1'b0;
          busy_reg        <= 1'b0;
          pend_finish_reg <= 1'b0;
          state_reg       <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_reg;
  assign imem_we     = imem_we_reg;
  assign imem_addr   = addr_reg;
  assign imem_wdata  = word_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign word_count  = word_count_reg;
  assign err_illegal = err_illegal_reg;
  assign full        = full_reg;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader with MAX_WORDS=4; expected words
// are hand-encoded from the MIPS field layouts.
module tb_instr_encode_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              finish = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [2:0]        req_class = '0;
  logic [5:0]        req_func = '0;
  logic [4:0]        req_rs = '0, req_rt = '0, req_rd = '0, req_shamt = '0;
  logic [15:0]       req_imm = '0;
  logic [25:0]       req_target = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ready = 1'b1;
  logic              busy, done, err_illegal, full;
  logic [ADDR_W:0]   word_count;

  int total = 0;
  int bad = 0;

  logic [ADDR_W-1:0] wr_addr [0:63];
  logic [31:0]       wr_data [0:63];
  int                wr_cnt = 0;
  int                rd_idx = 0;
  int                done_cnt = 0;

  instr_encode_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready), .req_class(req_class),
    .req_func(req_func), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_imm(req_imm), .req_target(req_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .busy(busy), .done(done), .word_count(word_count),
    .err_illegal(err_illegal), .full(full)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so the negedge sees a settled cycle.
  always @(negedge clk) begin
    if (imem_we && imem_ready && wr_cnt < 64) begin
      wr_addr[wr_cnt] = imem_addr;
      wr_data[wr_cnt] = imem_wdata;
      wr_cnt = wr_cnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] base);
    base_addr = base; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    step();
    finish = 1'b0;
  endtask

  task automatic send(input string tag, input logic [2:0] cls, input logic [5:0] func,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tgt);
    bit ok = 0;
    int n = 0;
    req_class = cls; req_func = func; req_rs = rs; req_rt = rt; req_rd = rd;
    req_shamt = sh; req_imm = imm; req_target = tgt;
    req_valid = 1'b1;
    while (!ok && n < 20) begin
      if (req_ready) ok = 1;
      step();
      n++;
    end
    req_valid = 1'b0;
    if (!ok) chk({tag, " accept_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic expect_write(input string tag, input logic [ADDR_W-1:0] addr,
                              input logic [31:0] data);
    int n = 0;
    while (wr_cnt <= rd_idx && n < 20) begin
      step();
      n++;
    end
    if (wr_cnt <= rd_idx) begin
      chk({tag, " write_timeout"}, 32'd0, 32'd1);
    end else begin
      $display("%s: write addr=%h data=%h", tag, wr_addr[rd_idx], wr_data[rd_idx]);
      chk({tag, " addr"}, 32'(wr_addr[rd_idx]), 32'(addr));
      chk({tag, " data"}, wr_data[rd_idx], data);
      rd_idx++;
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    if (!req_ready) chk({tag, " ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    if (busy) chk({tag, " idle_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int d0;
    int acc;
    repeat (3) step();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst imem_we", 32'(imem_we), 32'd0);
    chk("rst word_count", 32'(word_count), 32'd0);
    chk("rst flags", {29'd0, done, full, err_illegal}, 32'd0);
    rst = 1'b0;
    step();

    // Session 1: R and LUI, then finish from ACCEPT.
    d0 = done_cnt;
    pulse_start(8'h10);
    chk("s1 busy", 32'(busy), 32'd1);
    send("s1 r", 3'd0, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    chk("s1 we latency", 32'(imem_we), 32'd1);
    expect_write("s1 r", 8'h10, 32'h00221820);
    wait_ready("s1 r");
    chk("s1 count1", 32'(word_count), 32'd1);
    send("s1 lui", 3'd1, 6'h07, 5'd5, 5'd8, 5'd0, 5'd0, 16'h1234, 26'h0);
    expect_write("s1 lui", 8'h11, 32'h3C081234);
    wait_ready("s1 lui");
    pulse_finish();
    wait_idle("s1");
    chk("s1 done pulses", 32'(done_cnt - d0), 32'd1);
    chk("s1 count held", 32'(word_count), 32'd2);

    // Session 2: LOAD, illegal class, BRANCH to the unconsumed address.
    d0 = done_cnt;
    pulse_start(8'h20);
    send("s2 load", 3'd2, 6'h03, 5'd29, 5'd9, 5'd0, 5'd0, 16'h0004, 26'h0);
    expect_write("s2 load", 8'h20, 32'h8FA90004);
    wait_ready("s2 load");
    send("s2 illegal", 3'd6, 6'h00, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
    step();
    $display("s2 illegal: err_illegal=%0d word_count=%0d", err_illegal, word_count);
    chk("s2 err_illegal", 32'(err_illegal), 32'd1);
    chk("s2 no write", 32'(wr_cnt - rd_idx), 32'd0);
    chk("s2 count", 32'(word_count), 32'd1);
    chk("s2 still ready", 32'(req_ready), 32'd1);
    send("s2 bne", 3'd4, 6'h01, 5'd4, 5'd0, 5'd0, 5'd0, 16'hFFFE, 26'h0);
    expect_write("s2 bne", 8'h21, 32'h1480FFFE);
    wait_ready("s2 bne");
    pulse_finish();
    wait_idle("s2");
    chk("s2 done pulses", 32'(done_cnt - d0), 32'd1);
    chk("s2 err sticky", 32'(err_illegal), 32'd1);

    // Session 3: stalled write with finish arriving during WRITE.
    d0 = done_cnt;
    pulse_start(8'h30);
    chk("s3 err cleared", 32'(err_illegal), 32'd0);
    imem_ready = 1'b0;
    send("s3 sll", 3'd0, 6'h00, 5'd4, 5'd5, 5'd6, 5'd2, 16'h0, 26'h0);
    finish = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("s3 stall we", 32'(imem_we), 32'd1);
      chk("s3 stall addr", 32'(imem_addr), 32'h30);
      chk("s3 stall data", imem_wdata, 32'h00853080);
      step();
      finish = 1'b0;
    end
    imem_ready = 1'b1;
    expect_write("s3 sll", 8'h30, 32'h00853080);
    wait_idle("s3");
    chk("s3 done pulses", 32'(done_cnt - d0), 32'd1);
    chk("s3 count", 32'(word_count), 32'd1);

    // Session 4: wrap from 0xFE and auto-terminate at four words.
    d0 = done_cnt;
    pulse_start(8'hFE);
    for (int i = 0; i < 4; i++) begin
      send("s4 jal", 3'd5, 6'h01, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'(i + 1));
      expect_write("s4 jal", 8'(8'hFE + i), 32'h0C000000 | 32'(i + 1));
    end
    acc = 0;
    req_class = 3'd5; req_func = 6'h01; req_target = 26'h5;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (req_ready) acc++;
      step();
    end
    req_valid = 1'b0;
    $display("s4 fifth: accepted=%0d full=%0d word_count=%0d", acc, full, word_count);
    chk("s4 fifth refused", 32'(acc), 32'd0);
    chk("s4 no extra write", 32'(wr_cnt - rd_idx), 32'd0);
    chk("s4 full", 32'(full), 32'd1);
    chk("s4 count", 32'(word_count), 32'd4);
    chk("s4 done pulses", 32'(done_cnt - d0), 32'd1);
    chk("s4 idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
